// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin AXI4 read arbiter, one outstanding burst
module axi_rd_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   m0_arid,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [ID_WIDTH-1:0]   m0_rid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ID_WIDTH-1:0]   m1_arid,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [ID_WIDTH-1:0]   m1_rid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ID_WIDTH-1:0]   s_axi_arid,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic [1:0]            s_axi_arburst,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [ID_WIDTH-1:0]   s_axi_rid,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state, state_nxt;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic       win0, win1, accept, ar_hs, r_hs, sel0, sel1;

    // On a tie the master that did not win last time gets the slave.
    assign win0   = m0_arvalid & (~m1_arvalid | last_grant);
    assign win1   = m1_arvalid & (~m0_arvalid | ~last_grant);
    assign accept = (state == IDLE) & (win0 | win1);

    assign m0_arready = (state == IDLE) & win0;
    assign m1_arready = (state == IDLE) & win1;

    assign s_axi_arvalid = (state == ADDR);
    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign busy          = (state != IDLE);

    assign sel0 = (state == DATA) & grant[0];
    assign sel1 = (state == DATA) & grant[1];

    assign s_axi_rready = (sel0 & m0_rready) | (sel1 & m1_rready);
    assign r_hs         = (state == DATA) & s_axi_rvalid & s_axi_rready;

    assign m0_rvalid = sel0 & s_axi_rvalid;
    assign m0_rlast  = sel0 & s_axi_rlast;
    assign m0_rid    = sel0 ? s_axi_rid   : '0;
    assign m0_rdata  = sel0 ? s_axi_rdata : '0;
    assign m0_rresp  = sel0 ? s_axi_rresp : '0;
    assign m1_rvalid = sel1 & s_axi_rvalid;
    assign m1_rlast  = sel1 & s_axi_rlast;
    assign m1_rid    = sel1 ? s_axi_rid   : '0;
    assign m1_rdata  = sel1 ? s_axi_rdata : '0;
    assign m1_rresp  = sel1 ? s_axi_rresp : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADDR;
            ADDR:    if (ar_hs) state_nxt = DATA;
            DATA:    if (r_hs && s_axi_rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant         <= 2'b00;
            last_grant    <= 1'b1;
            beat_cnt      <= 8'd0;
            len_err       <= 1'b0;
            s_axi_arid    <= '0;
            s_axi_araddr  <= '0;
            s_axi_arlen   <= '0;
            s_axi_arsize  <= '0;
            s_axi_arburst <= '0;
        end else begin
            if (accept) begin
                grant         <= {win1, win0};
                last_grant    <= win1;
                beat_cnt      <= 8'd0;
                s_axi_arid    <= win1 ? m1_arid    : m0_arid;
                s_axi_araddr  <= win1 ? m1_araddr  : m0_araddr;
                s_axi_arlen   <= win1 ? m1_arlen   : m0_arlen;
                s_axi_arsize  <= win1 ? m1_arsize  : m0_arsize;
                s_axi_arburst <= win1 ? m1_arburst : m0_arburst;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                // Early or late rlast both flag; the burst still ends only on rlast.
                if (s_axi_rlast != (beat_cnt == s_axi_arlen)) begin
                    len_err <= 1'b1;
                end
                if (s_axi_rlast) begin
                    grant <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   m0_arid, m1_arid, s_axi_arid, m0_rid, m1_rid, s_axi_rid;
    logic [31:0]  m0_araddr, m1_araddr, s_axi_araddr;
    logic [7:0]   m0_arlen, m1_arlen, s_axi_arlen;
    logic [2:0]   m0_arsize, m1_arsize, s_axi_arsize;
    logic [1:0]   m0_arburst, m1_arburst, s_axi_arburst;
    logic         m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [255:0] m0_rdata, m1_rdata, s_axi_rdata;
    logic [1:0]   m0_rresp, m1_rresp, s_axi_rresp;
    logic         m0_rlast, m1_rlast, s_axi_rlast;
    logic         m0_rvalid, m1_rvalid, s_axi_rvalid;
    logic         m0_rready, m1_rready, s_axi_rready;
    logic         s_axi_arvalid, s_axi_arready;
    logic [1:0]   grant;
    logic         busy, len_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input int m, input logic v, input logic [31:0] addr, input logic [7:0] len);
        if (m == 0) begin
            m0_arvalid = v; m0_araddr = addr; m0_arlen = len; m0_arid = 4'h3;
        end else begin
            m1_arvalid = v; m1_araddr = addr; m1_arlen = len; m1_arid = 4'h9;
        end
    endtask

    task automatic serve_ar(input int m, input logic [31:0] addr, input logic [7:0] len);
        s_axi_arready = 1'b1;
        #1;
        check("ar_valid", s_axi_arvalid, 1'b1);
        check("ar_addr", s_axi_araddr, addr);
        check("ar_len", s_axi_arlen, len);
        check("ar_id", s_axi_arid, (m == 0) ? 4'h3 : 4'h9);
        check("ar_grant", grant, (m == 0) ? 2'b01 : 2'b10);
        step();
        s_axi_arready = 1'b0;
    endtask

    task automatic serve_r(input int m, input int n, input logic [255:0] base);
        for (int i = 0; i < n; i++) begin
            s_axi_rvalid = 1'b1;
            s_axi_rdata  = base + 256'(i);
            s_axi_rlast  = (i == n - 1);
            s_axi_rresp  = 2'b01;
            #1;
            check("r_valid", (m == 0) ? m0_rvalid : m1_rvalid, 1'b1);
            check("r_other", (m == 0) ? m1_rvalid : m0_rvalid, 1'b0);
            check("r_data", (m == 0) ? m0_rdata : m1_rdata, base + 256'(i));
            check("r_resp", (m == 0) ? m0_rresp : m1_rresp, 2'b01);
            check("r_ready", s_axi_rready, 1'b1);
            step();
        end
        s_axi_rvalid = 1'b0;
        s_axi_rlast  = 1'b0;
        #1;
        check("post_grant", grant, 2'b00);
        check("post_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req(0, 1'b0, 0, 0); req(1, 1'b0, 0, 0);
        m0_arsize = 3'd5; m1_arsize = 3'd5; m0_arburst = 2'b01; m1_arburst = 2'b01;
        m0_rready = 1'b1; m1_rready = 1'b1; s_axi_arready = 1'b0;
        s_axi_rid = 4'h3; s_axi_rdata = '0; s_axi_rresp = 2'b00; s_axi_rlast = 1'b0; s_axi_rvalid = 1'b0;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_arvalid", s_axi_arvalid, 1'b0);
        check("rst_araddr", s_axi_araddr, 32'h0);
        check("rst_len_err", len_err, 1'b0);

        // m0 alone, arlen 3
        req(0, 1'b1, 32'h100, 8'd3);
        #1;
        check("t1_m0_arready", m0_arready, 1'b1);
        check("t1_m1_arready", m1_arready, 1'b0);
        step();
        req(0, 1'b0, 32'h100, 8'd3);
        check("t1_busy", busy, 1'b1);
        serve_ar(0, 32'h100, 8'd3);
        serve_r(0, 4, 256'hA0);
        check("t1_len_err", len_err, 1'b0);

        // tie after reset: m0, then m1, then m0 again
        do_reset();
        req(0, 1'b1, 32'h200, 8'd1);
        req(1, 1'b1, 32'h300, 8'd0);
        #1;
        check("tie1_m0", m0_arready, 1'b1);
        check("tie1_m1", m1_arready, 1'b0);
        step();
        req(0, 1'b0, 32'h200, 8'd1);
        #1;
        check("tie1_m1_wait", m1_arready, 1'b0);
        serve_ar(0, 32'h200, 8'd1);
        serve_r(0, 2, 256'hB0);
        check("tie1_m1_next", m1_arready, 1'b1);
        step();
        req(1, 1'b0, 32'h300, 8'd0);
        serve_ar(1, 32'h300, 8'd0);
        serve_r(1, 1, 256'hC0);
        req(0, 1'b1, 32'h210, 8'd0);
        req(1, 1'b1, 32'h310, 8'd0);
        #1;
        check("tie3_m0", m0_arready, 1'b1);
        check("tie3_m1", m1_arready, 1'b0);
        step();
        req(0, 1'b0, 32'h210, 8'd0);
        req(1, 1'b0, 32'h310, 8'd0);
        serve_ar(0, 32'h210, 8'd0);
        serve_r(0, 1, 256'hD0);

        // arready stall with a competing request pending
        req(1, 1'b1, 32'h400, 8'd7);
        step();
        req(1, 1'b0, 32'h400, 8'd7);
        req(0, 1'b1, 32'h500, 8'd3);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_arvalid", s_axi_arvalid, 1'b1);
            check("stall_addr", s_axi_araddr, 32'h400);
            check("stall_m0_arready", m0_arready, 1'b0);
            check("stall_grant", grant, 2'b10);
            step();
        end
        serve_ar(1, 32'h400, 8'd7);

        // rready toggling on m1 during the arlen=7 burst
        begin
            int beat = 0;
            int cyc = 0;
            while (beat < 8 && cyc < 40) begin
                m1_rready    = (cyc % 2 == 0);
                s_axi_rvalid = 1'b1;
                s_axi_rdata  = 256'hE0 + 256'(beat);
                s_axi_rlast  = (beat == 7);
                #1;
                check("tog_rready", s_axi_rready, m1_rready);
                check("tog_data", m1_rdata, 256'hE0 + 256'(beat));
                check("tog_m0_rvalid", m0_rvalid, 1'b0);
                if (m1_rready) beat++;
                cyc++;
                step();
            end
            check("tog_beats", beat, 8);
            s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0; m1_rready = 1'b1;
        end
        #1;
        check("tog_len_err", len_err, 1'b0);
        check("pend_m0_arready", m0_arready, 1'b1);
        step();
        req(0, 1'b0, 32'h500, 8'd3);

        // early rlast on the third beat of an arlen=3 burst
        serve_ar(0, 32'h500, 8'd3);
        serve_r(0, 3, 256'hF0);
        check("early_len_err", len_err, 1'b1);
        req(1, 1'b1, 32'h600, 8'd0);
        step();
        req(1, 1'b0, 32'h600, 8'd0);
        serve_ar(1, 32'h600, 8'd0);
        serve_r(1, 1, 256'h1F0);
        check("sticky_len_err", len_err, 1'b1);

        // reset in the middle of a DATA beat
        req(0, 1'b1, 32'h700, 8'd3);
        step();
        req(0, 1'b0, 32'h700, 8'd3);
        serve_ar(0, 32'h700, 8'd3);
        s_axi_rvalid = 1'b1; s_axi_rdata = 256'h77; s_axi_rlast = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_grant", grant, 2'b00);
        check("mid_busy", busy, 1'b0);
        check("mid_arvalid", s_axi_arvalid, 1'b0);
        check("mid_araddr", s_axi_araddr, 32'h0);
        check("mid_len_err", len_err, 1'b0);
        check("mid_m0_rvalid", m0_rvalid, 1'b0);
        check("mid_rready", s_axi_rready, 1'b0);
        s_axi_rvalid = 1'b0;
        step();
        rst_n = 1'b1;
        req(0, 1'b1, 32'h800, 8'd0);
        req(1, 1'b1, 32'h900, 8'd0);
        #1;
        check("rst_tie_m0", m0_arready, 1'b1);
        check("rst_tie_m1", m1_arready, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master, one-slave AXI4 read-channel arbiter that shares the window-RAM read port (256-bit `s_axi_*`) between the debug UART reader (master 0) and the AXIS/PS-side reader (master 1). It grants round-robin, registers and re-issues the winning AR request, and routes the R beats back to the granted master until `rlast`. It also checks burst length and reports a sticky error. Only one burst is outstanding at any time.

## Interface
Parameters:
- `DATA_WIDTH`, 256, R data width
- `ADDR_WIDTH`, 32, AR address width
- `ID_WIDTH`, 4, AR/R id width

Ports (N = 0, 1; `mN_*` are per-master copies):
- `clk` input 1: single clock for all logic
- `rst_n` input 1: asynchronous, active-low reset
- `mN_arid` input ID_WIDTH: master read id
- `mN_araddr` input ADDR_WIDTH: master read address
- `mN_arlen` input 8: beats minus 1
- `mN_arsize` input 3: AXI size, passed through
- `mN_arburst` input 2: AXI burst type, passed through
- `mN_arvalid` input 1: master AR valid
- `mN_arready` output 1: master AR accept
- `mN_rid` output ID_WIDTH: routed `s_axi_rid`
- `mN_rdata` output DATA_WIDTH: routed `s_axi_rdata`
- `mN_rresp` output 2: routed `s_axi_rresp`
- `mN_rlast` output 1: routed `s_axi_rlast`
- `mN_rvalid` output 1: routed `s_axi_rvalid`
- `mN_rready` input 1: master R ready
- `s_axi_arid`, `s_axi_araddr`, `s_axi_arlen`, `s_axi_arsize`, `s_axi_arburst` output: registered request fields
- `s_axi_arvalid` output 1: registered AR valid to slave
- `s_axi_arready` input 1: slave AR ready
- `s_axi_rid`, `s_axi_rdata`, `s_axi_rresp`, `s_axi_rlast`, `s_axi_rvalid` input: slave R channel
- `s_axi_rready` output 1: granted master's `rready`
- `grant` output 2: one-hot owner, 00 when idle
- `busy` output 1: state ≠ IDLE
- `len_err` output 1: sticky; set when the `rlast` position ≠ latched `arlen`

## Operation
- FSM states:
  - IDLE → ADDR on an accepted master AR.
  - ADDR → DATA on `s_axi_arvalid & s_axi_arready`.
  - DATA → IDLE on `s_axi_rvalid & s_axi_rready & s_axi_rlast`.
- Arbitration (IDLE only, combinational):
  - Winner is the requesting master when only one `mN_arvalid` is high.
  - When both are high, winner is the master ≠ `last_grant`.
  - `mN_arready` = IDLE & (winner == N); at most one is high. No acceptance occurs outside IDLE.
- On acceptance:
  - Latch arid, araddr, arlen, arsize, arburst into registers that drive `s_axi_ar*`.
  - Set `grant` and `last_grant`; clear the beat counter.
- ADDR: `s_axi_arvalid` = 1 and fields are held stable until `s_axi_arready`.
- DATA:
  - `s_axi_r*` are forwarded combinationally to the granted master; the other master sees `rvalid`=0 and all other R outputs 0.
  - `s_axi_rready` = granted `mN_rready`.
  - Non-DATA states: all `mN_rvalid` = 0 and `s_axi_rready` = 0.
- Beat counter (8 bit): increments on each R handshake.
  - `len_err` sets on an `rlast` handshake when count ≠ latched arlen.
  - `len_err` also sets on a non-`rlast` handshake when count == arlen.
  - In both cases the FSM still waits for `rlast`. `len_err` clears only on reset.
- `rresp` and `rid` are passed unchanged; no id checking.

## Timing
- Reset (async assert, sync-released by the system) forces these outputs and registers:
  - state IDLE, `grant` 00, `busy` 0, `s_axi_arvalid` 0
  - `s_axi_ar*` fields 0, `len_err` 0
  - `last_grant` = 1, so master 0 wins the first tie
- Reset mid-burst abandons the transfer. The slave is reset in the same domain, so there is no drain.
- AR latency: accept in cycle T (`mN_arready`=1) → `s_axi_arvalid`=1 from T+1.
- DATA is entered on the cycle after the slave AR handshake. An R beat may be forwarded in that same cycle.
- After the `rlast` handshake in cycle T, state is IDLE at T+1, and a new grant can be accepted in T+1. Back-to-back bursts therefore have one bubble cycle.
- A request that arrives while not IDLE waits; its `arvalid` must stay high per AXI.
- Simultaneous `rlast` handshake and a new `arvalid` in the same cycle: the new request is not accepted until T+1.

## Test plan
- Reset, then m0 alone requests araddr 0x100, arlen 3 → `m0_arready` in the same cycle, `s_axi_arvalid` the next cycle with 0x100/3; 4 beats reach m0, m1 sees `rvalid`=0, `grant`=01 → 00 after `rlast`, `len_err`=0.
- Both masters request in the same cycle after reset → m0 is served first; m1 is accepted one cycle after m0's `rlast` handshake; a third simultaneous tie goes to m0 again.
- Slave holds `s_axi_arready` low for 5 cycles → AR fields are stable and `s_axi_arvalid` is held; no second grant occurs.
- Master `rready` toggles 1/0 during an arlen=7 burst → `s_axi_rready` mirrors it; all 8 beats are delivered in order with no loss.
- Slave asserts `rlast` on beat 2 of an arlen=3 burst → `len_err`=1 and stays set; FSM returns to IDLE; the next burst proceeds normally.
- Assert `rst_n`=0 in the middle of a DATA beat → all outputs return to their reset values immediately, and m0 wins the first tie after reset.
